init: RTL and testbench
=======================

Name: init

Overview:
- ARC4 state-array initialiser: on request, writes S[i] = i for i = 0..255 into an external 256x8 single-port RAM (the S memory), one byte per clock.
- Sits beside the key-schedule and PRGA blocks. A top-level controller starts it with an en/rdy handshake and then hands the S-memory port to the next stage.

Parameters:
- None. Address width, data width and length (256 entries) are fixed by ARC4.

Ports:
- clk     input   1  system clock; all state changes on rising edge
- rst_n   input   1  asynchronous, active-low reset
- en      input   1  start request; accepted only on a rising edge where rdy=1
- rdy     output  1  1 = idle and able to accept a request; 0 = busy
- addr    output  8  S-memory write address
- wrdata  output  8  S-memory write data
- wren    output  1  S-memory write enable; 1 for exactly one cycle per byte

Behaviour:
- Internal state register `state` with encodings IDLE and WRITE, plus 8-bit counter i. Both state names are visible to the bench as dut.state, dut.IDLE and dut.WRITE.
- Reset (rst_n=0, asynchronous, applied regardless of clk):
  - state=IDLE, i=0, rdy=1, wren=0, addr=0, wrdata=0.
  - Reset mid-operation aborts the fill immediately. No further writes occur; the memory contents are left partially written.
- IDLE:
  - rdy=1, wren=0, addr=0, wrdata=0.
  - On a rising edge with en=1: state->WRITE, i->0, rdy->0 on that same edge.
  - With en=0 the block stays in IDLE.
- WRITE:
  - rdy=0, wren=1, addr=i, wrdata=i, all driven combinationally from the counter so they are stable for the full cycle.
  - Each rising edge performs one write, then i increments by 1.
  - On the edge that completes the write with i=255: state->IDLE, i->0, rdy->1. The counter does not wrap into a second pass.
- Latency and timing:
  - Exactly 256 consecutive wren=1 cycles, addresses 0,1,...,255 in order, data equal to address.
  - First write cycle is the cycle immediately after en is accepted.
  - rdy returns to 1 in the cycle after the last write (257 cycles after acceptance).
- en handling:
  - en is ignored while rdy=0. Holding en high through the whole operation causes no restart.
  - If en is still 1 on the first IDLE edge after completion, a new fill starts, which is legal.
  - en may drop any time after acceptance.
- Outputs never change except through a clock edge or reset. There are no glitches on wren outside WRITE.
- No undefined outputs after reset; X on en while rdy=0 has no effect.

Test Plan:
- Reset: hold rst_n=0 for one clock -> state==IDLE, rdy=1, wren=0, addr=0, wrdata=0. Also assert rst_n low between edges -> outputs reset immediately, without waiting for a clock edge.
- Start: release rst_n with en=1, then one rising edge -> state==WRITE, rdy=0, wren=1, addr=0, wrdata=0. Drop en to 0.
- Fill sequence: clock 256 cycles, checking each cycle -> addr==wrdata==k for k=0..255 in order with wren=1. The next cycle shows rdy=1, wren=0, state==IDLE. A shadow memory model equals identity (S[k]=k) for all 256 entries.
- en held high throughout: keep en=1 for 300 cycles -> exactly one 256-write pass, then rdy=1 for one cycle. A second pass then starts at addr 0; there is no restart mid-pass.
- Reset mid-fill: assert rst_n=0 while addr==100 -> wren=0, rdy=1, state==IDLE immediately. Re-start with en -> writes begin again at addr 0.
- Idle without en: keep en=0 for 20 cycles after reset -> wren never asserts, rdy stays 1.

Source files
------------

// File: rtl/init.sv
// ARC4 S-array initialiser: fills an external 256x8 RAM with S[i] = i,
// one byte per clock, started by an en/rdy handshake.
module init (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] addr,
    output logic [7:0] wrdata,
    output logic       wren
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] i;
    logic [7:0] i_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            i     <= 8'd0;
        end else begin
            state <= state_nxt;
            i     <= i_nxt;
        end
    end

    // Outputs decode from registered state only, so they move solely on
    // a clock edge or reset and never glitch.
    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        rdy       = 1'b1;
        wren      = 1'b0;
        addr      = 8'd0;
        wrdata    = 8'd0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = WRITE;
                    i_nxt     = 8'd0;
                end
            end
            WRITE: begin
                rdy    = 1'b0;
                wren   = 1'b1;
                addr   = i;
                wrdata = i;
                i_nxt  = i + 8'd1;
                if (i == 8'hff) begin
                    state_nxt = IDLE;
                    i_nxt     = 8'd0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_init.sv
// Self-checking bench for init: scoreboard of expected S-memory writes,
// shadow memory model, reset/abort and en-hold scenarios.
module tb_init;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       rdy;
    logic [7:0] addr;
    logic [7:0] wrdata;
    logic       wren;

    int checks;
    int errors;

    typedef struct packed {
        logic       wren;
        logic [7:0] addr;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] shadow[256];

    init dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .rdy    (rdy),
        .addr   (addr),
        .wrdata (wrdata),
        .wren   (wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dut.state !== dut.IDLE || rdy !== 1'b1 || wren !== 1'b0 ||
            addr !== 8'd0 || wrdata !== 8'd0) begin
            errors++;
            $display("FAIL reset: state=%0d rdy=%0b wren=%0b addr=%0d wrdata=%0d want IDLE,1,0,0,0",
                     dut.state, rdy, wren, addr, wrdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        en  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (wren !== 1'b0 || rdy !== 1'b1) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL idle c%0d: wren=%0b rdy=%0b want 0,1", c, wren, rdy);
            end
        end
    endtask

    task automatic test_fill();
        exp_t e;
        for (int k = 0; k < 256; k++) shadow[k] = 8'(k) ^ 8'hff;
        sb.delete();
        en = 1'b1;
        for (int k = 0; k < 256; k++) sb.push_back('{wren: 1'b1, addr: 8'(k)});
        @(negedge clk);
        checks++;
        if (dut.state !== dut.WRITE || rdy !== 1'b0) begin
            errors++;
            $display("FAIL start: state=%0d rdy=%0b want WRITE,0", dut.state, rdy);
        end
        en = 1'b0;
        for (int k = 0; k < 256; k++) begin
            e = sb.pop_front();
            checks++;
            if (wren !== e.wren || addr !== e.addr || wrdata !== e.addr) begin
                errors++;
                $display("FAIL fill k%0d: wren=%0b addr=%0d wrdata=%0d want 1,%0d,%0d",
                         k, wren, addr, wrdata, e.addr, e.addr);
            end
            if (wren === 1'b1) shadow[addr] = wrdata;
            @(negedge clk);
        end
        checks++;
        if (rdy !== 1'b1 || wren !== 1'b0 || dut.state !== dut.IDLE) begin
            errors++;
            $display("FAIL fill_done: rdy=%0b wren=%0b state=%0d want 1,0,IDLE",
                     rdy, wren, dut.state);
        end
        for (int k = 0; k < 256; k++) begin
            checks++;
            if (shadow[k] !== 8'(k)) begin
                errors++;
                $display("FAIL shadow[%0d]: got %0d want %0d", k, shadow[k], k);
            end
        end
    endtask

    task automatic test_en_held();
        exp_t e;
        sb.delete();
        en = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (c < 256)       sb.push_back('{wren: 1'b1, addr: 8'(c)});
            else if (c == 256) sb.push_back('{wren: 1'b0, addr: 8'd0});
            else               sb.push_back('{wren: 1'b1, addr: 8'(c - 257)});
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (wren !== e.wren || addr !== e.addr || rdy !== ~e.wren) begin
                errors++;
                $display("FAIL en_held c%0d: wren=%0b addr=%0d rdy=%0b want %0b,%0d,%0b",
                         c, wren, addr, rdy, e.wren, e.addr, ~e.wren);
            end
        end
        en    = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 1'b0;
        sb.delete();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            if (wren === 1'b1 && addr == 8'd100) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reach_100: addr 100 not seen within budget, addr=%0d", addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wren !== 1'b0 || rdy !== 1'b1 || dut.state !== dut.IDLE ||
            addr !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: wren=%0b rdy=%0b state=%0d addr=%0d want 0,1,IDLE,0",
                     wren, rdy, dut.state, addr);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (wren !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: wren=%0b want 0", wren);
        end
        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 0; k < 6; k++) sb.push_back('{wren: 1'b1, addr: 8'(k)});
        for (int k = 0; k < 6; k++) begin
            exp_t e;
            @(negedge clk);
            en = 1'b0;
            e  = sb.pop_front();
            checks++;
            if (wren !== e.wren || addr !== e.addr || wrdata !== e.addr) begin
                errors++;
                $display("FAIL restart k%0d: wren=%0b addr=%0d wrdata=%0d want 1,%0d,%0d",
                         k, wren, addr, wrdata, e.addr, e.addr);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        test_reset();
        test_idle();
        test_fill();
        test_en_held();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
